axis_rx_framer: RTL and testbench

Return path to the Zynq, complementing the inbound TX FIFO. Accepts free-running 32-bit words from the local readout FSM, which has no backpressure, and buffers them. Emits them to the Zynq AXI-Stream DMA as length-prefixed frames terminated by tlast. Each frame is flushed when it is full or when a timeout expires, and overflow is counted rather than stalled.

---
 rtl/axis_rx_framer_pkg.sv | 30 +++
 rtl/axis_rx_framer_if.sv | 23 ++
 rtl/axis_rx_framer_fifo.sv | 55 +++++
 rtl/axis_rx_framer.sv | 145 ++++++++++++++
 tb/tb_axis_rx_framer.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/axis_rx_framer_pkg.sv
// Shared definitions for the readout-to-Zynq return path.
// Covers the frame header layout and the framer state encoding.
package qpix_axis_pkg;

  localparam int WORD_W = 32;
  localparam logic [7:0] FRAME_MAGIC = 8'hA5;

  localparam int MAGIC_MSB = 31;
  localparam int MAGIC_LSB = 24;
  localparam int SEQ_MSB   = 23;
  localparam int SEQ_LSB   = 16;
  localparam int LEN_MSB   = 15;
  localparam int LEN_LSB   = 0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    PAYLOAD = 2'd2
  } framer_state_e;

  function automatic logic [WORD_W-1:0] build_header(input logic [7:0] seq, input logic [15:0] len);
    logic [WORD_W-1:0] hdr;
    hdr = '0;
    hdr[MAGIC_MSB:MAGIC_LSB] = FRAME_MAGIC;
    hdr[SEQ_MSB:SEQ_LSB]     = seq;
    hdr[LEN_MSB:LEN_LSB]     = len;
    return hdr;
  endfunction

endpackage

// File: rtl/axis_rx_framer_if.sv
// Bundles the local write strobe and the outbound AXI-Stream channel.
// The master modport is the framer side; slave is the FSM/DMA side.
interface axis_rx_framer_if;
  import qpix_axis_pkg::*;

  logic [WORD_W-1:0] in_data;
  logic              in_valid;
  logic [WORD_W-1:0] m_axis_tdata;
  logic              m_axis_tlast;
  logic              m_axis_tvalid;
  logic              m_axis_tready;

  modport master (
    input  in_data, in_valid, m_axis_tready,
    output m_axis_tdata, m_axis_tlast, m_axis_tvalid
  );

  modport slave (
    output in_data, in_valid, m_axis_tready,
    input  m_axis_tdata, m_axis_tlast, m_axis_tvalid
  );

endinterface

// File: rtl/axis_rx_framer_fifo.sv
// Circular word buffer with first-word-fall-through head and a one-ahead peek,
// so the framer can register the next payload word on the same handshake that pops.
module rx_word_fifo #(
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en_i,
  input  logic [DATA_WIDTH-1:0]   wr_data_i,
  input  logic                    rd_en_i,
  output logic [$clog2(DEPTH):0]  level_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [DATA_WIDTH-1:0]   head_o,
  output logic [DATA_WIDTH-1:0]   head_next_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]           wr_ptr_q;
  logic [AW:0]           rd_ptr_q;
  logic [AW-1:0]         rdAddr;
  logic [AW-1:0]         rdAddrNext;
  logic                  wrOk;
  logic                  rdOk;

  assign wrOk       = wr_en_i & ~full_o;
  assign rdOk       = rd_en_i & ~empty_o;
  assign rdAddr     = rd_ptr_q[AW-1:0];
  assign rdAddrNext = rdAddr + AW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wrOk) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rdOk) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage is left unreset; only pointer-qualified entries are ever observed.
  always_ff @(posedge clk) begin
    if (wrOk) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

  assign level_o     = wr_ptr_q - rd_ptr_q;
  assign full_o      = (level_o == (AW+1)'(DEPTH));
  assign empty_o     = (wr_ptr_q == rd_ptr_q);
  assign head_o      = mem_q[rdAddr];
  assign head_next_o = mem_q[rdAddrNext];

endmodule

// File: rtl/axis_rx_framer.sv
// Buffers free-running readout words and ships them to the Zynq DMA as
// length-prefixed AXI-Stream frames, flushed on full frame or idle timeout.
module axis_rx_framer
  import qpix_axis_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_FRAME  = 8,
  parameter int TIMEOUT    = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  axis_rx_framer_if.master        bus,
  output logic [7:0]              frame_seq,
  output logic [15:0]             drop_cnt,
  output logic [$clog2(DEPTH):0]  buf_level
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [LW-1:0] MAX_LVL = LW'(MAX_FRAME);

  framer_state_e         state_q;
  logic [DATA_WIDTH-1:0] tdata_q;
  logic                  tvalid_q;
  logic                  tlast_q;
  logic [7:0]            seq_q;
  logic [15:0]           len_q;
  logic [15:0]           rem_q;
  logic [15:0]           drop_q;
  logic [TW-1:0]         tmo_q;
  logic [TW-1:0]         tmo_d;

  logic [LW-1:0]         level;
  logic                  full;
  logic                  empty;
  logic [DATA_WIDTH-1:0] head;
  logic [DATA_WIDTH-1:0] headNext;
  logic                  wrEn;
  logic                  popEn;
  logic                  frameFull;
  logic                  tmoHit;
  logic                  startFrame;
  logic [15:0]           lenNext;

  assign wrEn  = bus.in_valid & ~full;
  assign popEn = (state_q == PAYLOAD) & tvalid_q & bus.m_axis_tready;

  rx_word_fifo #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .wr_en_i     (wrEn),
    .wr_data_i   (bus.in_data),
    .rd_en_i     (popEn),
    .level_o     (level),
    .full_o      (full),
    .empty_o     (empty),
    .head_o      (head),
    .head_next_o (headNext)
  );

  // The frame starts on the edge where the idle counter would reach TIMEOUT-1.
  always_comb begin
    frameFull  = (level >= MAX_LVL);
    tmoHit     = (TIMEOUT < 2) || (int'(tmo_q) >= TIMEOUT - 2);
    startFrame = (state_q == IDLE) && !empty && (frameFull || tmoHit);
    lenNext    = frameFull ? 16'(MAX_FRAME) : 16'(level);
    tmo_d      = '0;
    if ((state_q == IDLE) && !empty && !startFrame) tmo_d = tmo_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_q  <= '0;
      drop_q <= '0;
    end else begin
      tmo_q <= tmo_d;
      if (bus.in_valid && full && (drop_q != 16'hFFFF)) drop_q <= drop_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      seq_q    <= '0;
      len_q    <= '0;
      rem_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          tdata_q  <= '0;
          tvalid_q <= 1'b0;
          tlast_q  <= 1'b0;
          if (startFrame) begin
            len_q   <= lenNext;
            state_q <= HEADER;
          end
        end
        HEADER: begin
          if (!tvalid_q) begin
            tdata_q  <= build_header(seq_q, len_q);
            tvalid_q <= 1'b1;
            tlast_q  <= 1'b0;
          end else if (bus.m_axis_tready) begin
            seq_q   <= seq_q + 8'd1;
            rem_q   <= len_q;
            tdata_q <= head;
            tlast_q <= (len_q == 16'd1);
            state_q <= PAYLOAD;
          end
        end
        PAYLOAD: begin
          // Head advances on the pop, so the word after it is what goes out next.
          if (bus.m_axis_tready) begin
            if (rem_q == 16'd1) begin
              tdata_q  <= '0;
              tvalid_q <= 1'b0;
              tlast_q  <= 1'b0;
              state_q  <= IDLE;
            end else begin
              rem_q   <= rem_q - 16'd1;
              tdata_q <= headNext;
              tlast_q <= (rem_q == 16'd2);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.m_axis_tdata  = tdata_q;
  assign bus.m_axis_tvalid = tvalid_q;
  assign bus.m_axis_tlast  = tlast_q;
  assign frame_seq         = seq_q;
  assign drop_cnt          = drop_q;
  assign buf_level         = level;

endmodule

// File: tb/tb_axis_rx_framer.sv
// Directed bench for axis_rx_framer: full frames, timeout flush, backpressure,
// overflow, sequence wrap and mid-frame reset, with hand-computed expectations.
module tb_axis_rx_framer;

  localparam int DEPTH     = 16;
  localparam int MAX_FRAME = 8;
  localparam int TIMEOUT   = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  frameSeq;
  logic [15:0] dropCnt;
  logic [4:0]  bufLevel;

  int checks = 0;
  int errors = 0;

  logic [32:0] rxQ[$];

  axis_rx_framer_if bus();

  axis_rx_framer #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (32),
    .MAX_FRAME  (MAX_FRAME),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .frame_seq (frameSeq),
    .drop_cnt  (dropCnt),
    .buf_level (bufLevel)
  );

  always #5 clk = ~clk;

  // Inputs change just after posedge, so a negedge sample predicts the next handshake.
  always @(negedge clk) begin
    if (!rst && bus.m_axis_tvalid && bus.m_axis_tready)
      rxQ.push_back({bus.m_axis_tlast, bus.m_axis_tdata});
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] data);
    bus.in_data  = data;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic writeBurst(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) applyStimulus(base + 32'(i));
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic waitWords(input int n, input int budget);
    int c;
    c = 0;
    while ((rxQ.size() < n) && (c < budget)) begin
      tick();
      c++;
    end
    checkOutput("wait_words", 64'(rxQ.size()), 64'(n));
  endtask

  task automatic checkFrame(input string tag, input logic [7:0] seq, input int len,
                            input logic [31:0] base, input int start);
    logic [32:0] hdr;
    logic [32:0] exp;
    hdr = {1'b0, 8'hA5, seq, 16'(len)};
    checkOutput({tag, "_hdr"}, 64'(rxQ[start]), 64'(hdr));
    for (int i = 0; i < len; i++) begin
      exp = {(i == len - 1), base + 32'(i)};
      checkOutput($sformatf("%s_w%0d", tag, i), 64'(rxQ[start + 1 + i]), 64'(exp));
    end
  endtask

  task automatic doReset();
    #2 rst = 1'b1;
    #4 rst = 1'b0;
    tick();
  endtask

  initial begin
    bus.in_data       = '0;
    bus.in_valid      = 1'b0;
    bus.m_axis_tready = 1'b1;
    #12 rst = 1'b0;
    tick();

    $display("[TB] reset state");
    checkOutput("rst_stream", {bus.m_axis_tvalid, bus.m_axis_tlast, bus.m_axis_tdata}, 34'h0);
    checkOutput("rst_seq", frameSeq, 8'h00);
    checkOutput("rst_drop", dropCnt, 16'h0000);
    checkOutput("rst_level", bufLevel, 5'd0);

    $display("[TB] full frame");
    rxQ.delete();
    writeBurst(32'h100, 8);
    checkOutput("lat_n0", bus.m_axis_tvalid, 1'b0);
    checkOutput("lat_level", bufLevel, 5'd8);
    tick();
    checkOutput("lat_n1", bus.m_axis_tvalid, 1'b0);
    tick();
    checkOutput("lat_n2", {bus.m_axis_tvalid, bus.m_axis_tlast, bus.m_axis_tdata}, {2'b10, 32'hA5000008});
    waitWords(9, 40);
    checkFrame("full", 8'h00, 8, 32'h100, 0);
    checkOutput("full_seq", frameSeq, 8'h01);
    checkOutput("full_level", bufLevel, 5'd0);

    $display("[TB] backpressure");
    rxQ.delete();
    bus.m_axis_tready = 1'b0;
    writeBurst(32'h100, 8);
    for (int c = 0; (c < 20) && !bus.m_axis_tvalid; c++) tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("bp_hdr_hold", {bus.m_axis_tvalid, bus.m_axis_tlast, bus.m_axis_tdata}, {2'b10, 32'hA5010008});
    end
    bus.m_axis_tready = 1'b1;
    for (int c = 0; (c < 20) && !(bus.m_axis_tvalid && (bus.m_axis_tdata == 32'h103)); c++) tick();
    bus.m_axis_tready = 1'b0;
    checkOutput("bp_found_103", bus.m_axis_tdata, 32'h103);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("bp_w3_hold", {bus.m_axis_tvalid, bus.m_axis_tlast, bus.m_axis_tdata}, {2'b10, 32'h103});
    end
    bus.m_axis_tready = 1'b1;
    waitWords(9, 40);
    checkFrame("bp", 8'h01, 8, 32'h100, 0);

    $display("[TB] timeout flush");
    rxQ.delete();
    applyStimulus(32'h200);
    applyStimulus(32'h201);
    applyStimulus(32'h202);
    repeat (29) tick();
    checkOutput("tmo_early", bus.m_axis_tvalid, 1'b0);
    tick();
    checkOutput("tmo_hdr", {bus.m_axis_tvalid, bus.m_axis_tdata}, {1'b1, 32'hA5020003});
    waitWords(4, 20);
    checkFrame("tmo", 8'h02, 3, 32'h200, 0);

    $display("[TB] overflow");
    rxQ.delete();
    bus.m_axis_tready = 1'b0;
    writeBurst(32'h300, 20);
    checkOutput("ovf_level", bufLevel, 5'd16);
    checkOutput("ovf_drop", dropCnt, 16'd4);
    checkOutput("ovf_hdr_wait", {bus.m_axis_tvalid, bus.m_axis_tdata}, {1'b1, 32'hA5030008});
    bus.m_axis_tready = 1'b1;
    waitWords(18, 80);
    checkFrame("ovf_a", 8'h03, 8, 32'h300, 0);
    checkFrame("ovf_b", 8'h04, 8, 32'h308, 9);
    repeat (40) tick();
    checkOutput("ovf_no_extra", 64'(rxQ.size()), 64'd18);
    checkOutput("ovf_level_end", bufLevel, 5'd0);

    $display("[TB] reset mid-frame");
    rxQ.delete();
    writeBurst(32'h400, 8);
    waitWords(4, 40);
    #2 rst = 1'b1;
    #1;
    checkOutput("mid_rst_stream", {bus.m_axis_tvalid, bus.m_axis_tlast, bus.m_axis_tdata}, 34'h0);
    checkOutput("mid_rst_seq", frameSeq, 8'h00);
    checkOutput("mid_rst_drop", dropCnt, 16'h0000);
    checkOutput("mid_rst_level", bufLevel, 5'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    tick();
    rxQ.delete();
    writeBurst(32'h500, 8);
    waitWords(9, 40);
    checkFrame("post_rst", 8'h00, 8, 32'h500, 0);

    $display("[TB] sequence wrap");
    doReset();
    for (int f = 0; f < 257; f++) begin
      rxQ.delete();
      writeBurst(32'h1000 + 32'(f * 8), 8);
      waitWords(9, 40);
      checkFrame("wrap", f[7:0], 8, 32'h1000 + 32'(f * 8), 0);
    end
    tick();
    checkOutput("wrap_seq_end", frameSeq, 8'h01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
